// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types for the memory access unit.
//   mau_state_e  - dispatch FSM states (IDLE, ACCESS, DONE)
//   mau_entry_t  - one queued load/store request
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mau_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_store;
        logic        found;     // load data already forwarded in .data
    } mau_entry_t;

endpackage

// File: rtl/mau_fifo.sv
// mau_fifo: request queue for mem_access_unit.
//   clk_i, rstn_i    - clock, async active-low reset
//   push_i, wdata_i  - write an entry (caller guarantees room, or a same-cycle pop)
//   pop_i, rdata_o   - head entry is shown combinationally; pop_i advances it
//   full_o, empty_o  - occupancy flags from the current (pre-edge) count
module mau_fifo
    import mem_access_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  mau_entry_t wdata_i,
    output mau_entry_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);

    mau_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: queued, in-order load/store unit with a private data memory.
//   Inputs : clk, rstn (async active-low), pcIn/addressIn/dataIn/loadStore/
//            alreadyFound describe the offered op, noIssue=1 means none offered.
//   Outputs: queueFull (queue holds DEPTH entries), doneValid one-cycle
//            completion pulse with payload pcDone/loadData/doneIsStore.
//   Build option: LOAD_BYPASS_EN lets forwarded loads skip the memory access.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 1024,
    parameter int MEM_LAT   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pcIn,
    input  logic [31:0] addressIn,
    input  logic [31:0] dataIn,
    input  logic        loadStore,
    input  logic        alreadyFound,
    input  logic        noIssue,
    output logic        queueFull,
    output logic        doneValid,
    output logic [31:0] pcDone,
    output logic [31:0] loadData,
    output logic        doneIsStore
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    mau_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mau_entry_t    cur_q, cur_d, head, push_ent;
    logic [31:0]   pc_q, pc_d, ld_q, ld_d;
    logic          st_q, st_d;
    logic          pop, push, full, empty, mem_we;
    logic [IW-1:0] cur_idx;
    logic          unused_addr;

    logic [31:0]   mem [MEM_WORDS];

    assign push_ent = '{pc: pcIn, addr: addressIn, data: dataIn,
                        is_store: loadStore, found: alreadyFound};
    // A full queue still takes the op when the FSM pops in the same cycle.
    assign push = !noIssue && (!full || pop);

    mau_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_ent),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Byte offset and bits above the array are dropped: addresses alias.
    assign cur_idx     = cur_q.addr[IW+1:2];
    assign unused_addr = ^{cur_q.addr[31:IW+2], cur_q.addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        pc_d    = pc_q;
        ld_d    = ld_q;
        st_d    = st_q;
        pop     = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Final access cycle: memory op and completion payload.
                    state_d = DONE;
                    pc_d    = cur_q.pc;
                    st_d    = cur_q.is_store;
                    mem_we  = cur_q.is_store;
                    if (cur_q.is_store)   ld_d = 32'd0;
                    else if (cur_q.found) ld_d = cur_q.data;
                    else                  ld_d = mem[cur_idx];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                // IDLE and DONE dispatch identically.
                state_d = IDLE;
                if (!empty) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    cnt_d   = CW'(MEM_LAT - 1);
                    state_d = ACCESS;
`ifdef LOAD_BYPASS_EN
                    if (!head.is_store && head.found) begin
                        state_d = DONE;
                        pc_d    = head.pc;
                        st_d    = 1'b0;
                        ld_d    = head.data;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            pc_q    <= '0;
            ld_q    <= '0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            pc_q    <= pc_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
        end
    end

    // No reset on the array. Reset forces state_q out of ACCESS at once,
    // which drops mem_we, so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (mem_we) mem[cur_idx] <= cur_q.data;
    end

    assign queueFull   = full;
    assign doneValid   = (state_q == DONE);
    assign pcDone      = pc_q;
    assign loadData    = ld_q;
    assign doneIsStore = st_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam int DEPTH = 4, MEM_WORDS = 1024, MEM_LAT = 2;
`ifdef LOAD_BYPASS_EN
    localparam int FWD_LAT = 1;
`else
    localparam int FWD_LAT = MEM_LAT + 1;
`endif

    logic        clk = 1'b0, rstn = 1'b1;
    logic [31:0] pcIn = '0, addressIn = '0, dataIn = '0;
    logic        loadStore = 1'b0, alreadyFound = 1'b0, noIssue = 1'b1;
    logic        queueFull, doneValid, doneIsStore;
    logic [31:0] pcDone, loadData;

    mem_access_unit #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rstn(rstn), .pcIn(pcIn), .addressIn(addressIn), .dataIn(dataIn),
        .loadStore(loadStore), .alreadyFound(alreadyFound), .noIssue(noIssue),
        .queueFull(queueFull), .doneValid(doneValid), .pcDone(pcDone),
        .loadData(loadData), .doneIsStore(doneIsStore)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        st;
        int          cyc;
    } cmp_t;

    cmp_t        exp_q[$], obs_q[$];
    logic [31:0] refmem [MEM_WORDS];
    int          total = 0, bad = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rstn && doneValid) obs_q.push_back('{pcDone, loadData, doneIsStore, cyc});

    // Reference: ops complete in issue order, so memory effects apply at issue time.
    task automatic model(input logic [31:0] pc, addr, data, input logic st, found);
        int idx = int'((addr >> 2) % MEM_WORDS);
        if (st) begin
            refmem[idx] = data;
            exp_q.push_back('{pc, 32'h0, 1'b1, 0});
        end else begin
            exp_q.push_back('{pc, found ? data : refmem[idx], 1'b0, 0});
        end
    endtask

    // Offer one op starting at a negedge; held until the unit takes it
    // (room in the queue, or a DONE cycle that pops at the same edge).
    task automatic offer(input logic [31:0] pc, addr, data, input logic st, found, output int acc_cyc);
        int g = 0;
        pcIn = pc; addressIn = addr; dataIn = data; loadStore = st; alreadyFound = found; noIssue = 1'b0;
        while (queueFull && !doneValid && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) begin
            total++; bad++;
            $display("FAIL offer_timeout pc=%h never accepted", pc);
        end else model(pc, addr, data, st, found);
        @(negedge clk);
        acc_cyc = cyc;
        noIssue = 1'b1;
    endtask

    task automatic wait_drain(output bit ok);
        int g = 0;
        while (obs_q.size() < exp_q.size() && g < 500) begin @(negedge clk); g++; end
        ok = (obs_q.size() >= exp_q.size());
        repeat (MEM_LAT + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #2;
        total++; if (doneValid !== 1'b0)    begin bad++; $display("FAIL rst_doneValid got=%b exp=0", doneValid); end
        total++; if (queueFull !== 1'b0)    begin bad++; $display("FAIL rst_queueFull got=%b exp=0", queueFull); end
        total++; if (pcDone !== 32'h0)      begin bad++; $display("FAIL rst_pcDone got=%h exp=0", pcDone); end
        total++; if (loadData !== 32'h0)    begin bad++; $display("FAIL rst_loadData got=%h exp=0", loadData); end
        total++; if (doneIsStore !== 1'b0)  begin bad++; $display("FAIL rst_doneIsStore got=%b exp=0", doneIsStore); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        bit ok; int c0, c1;
        exp_q.delete(); obs_q.delete();
        offer(32'h4, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, c0);
        offer(32'h8, 32'h100, 32'h0, 1'b0, 1'b0, c1);
        wait_drain(ok);
        total++; if (!ok || obs_q.size() != 2) begin bad++; $display("FAIL sl_count got=%0d exp=2", obs_q.size()); end
        if (obs_q.size() >= 2) begin
            total++; if (obs_q[0].st !== 1'b1 || obs_q[0].pc !== 32'h4 || obs_q[0].data !== 32'h0)
                begin bad++; $display("FAIL sl_store got pc=%h st=%b data=%h exp pc=4 st=1 data=0", obs_q[0].pc, obs_q[0].st, obs_q[0].data); end
            total++; if (obs_q[1].st !== 1'b0 || obs_q[1].pc !== 32'h8 || obs_q[1].data !== 32'hDEADBEEF)
                begin bad++; $display("FAIL sl_load got pc=%h st=%b data=%h exp pc=8 st=0 data=deadbeef", obs_q[1].pc, obs_q[1].st, obs_q[1].data); end
            total++; if (obs_q[0].cyc - c0 != MEM_LAT + 1)
                begin bad++; $display("FAIL sl_lat_store got=%0d exp=%0d", obs_q[0].cyc - c0, MEM_LAT + 1); end
            total++; if (obs_q[1].cyc - obs_q[0].cyc != MEM_LAT + 1)
                begin bad++; $display("FAIL sl_lat_load got=%0d exp=%0d", obs_q[1].cyc - obs_q[0].cyc, MEM_LAT + 1); end
        end
    endtask

    task automatic test_forward();
        bit ok; int c;
        exp_q.delete(); obs_q.delete();
        offer(32'h10, 32'h0, 32'h0, 1'b1, 1'b0, c);
        wait_drain(ok);
        exp_q.delete(); obs_q.delete();
        offer(32'h14, 32'h0, 32'h55, 1'b0, 1'b1, c);
        wait_drain(ok);
        total++; if (!ok || obs_q.size() != 1) begin bad++; $display("FAIL fwd_count got=%0d exp=1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            total++; if (obs_q[0].data !== 32'h55 || obs_q[0].st !== 1'b0 || obs_q[0].pc !== 32'h14)
                begin bad++; $display("FAIL fwd_data got pc=%h data=%h st=%b exp pc=14 data=55 st=0", obs_q[0].pc, obs_q[0].data, obs_q[0].st); end
            total++; if (obs_q[0].cyc - c != FWD_LAT)
                begin bad++; $display("FAIL fwd_lat got=%0d exp=%0d", obs_q[0].cyc - c, FWD_LAT); end
        end
    endtask

    task automatic test_wrap();
        bit ok; int c;
        exp_q.delete(); obs_q.delete();
        offer(32'h20, 32'h1000, 32'hCAFEF00D, 1'b1, 1'b0, c);
        offer(32'h24, 32'h0, 32'h0, 1'b0, 1'b0, c);
        wait_drain(ok);
        total++; if (!ok || obs_q.size() != 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", obs_q.size()); end
        if (obs_q.size() >= 2) begin
            total++; if (obs_q[1].data !== 32'hCAFEF00D || obs_q[1].pc !== 32'h24)
                begin bad++; $display("FAIL wrap_load got pc=%h data=%h exp pc=24 data=cafef00d", obs_q[1].pc, obs_q[1].data); end
        end
    endtask

    // Back-to-back stores: one slot in flight + DEPTH queued, so the first
    // refusal is op 6; op 7 lands on a DONE pop and is taken while full.
    task automatic test_fill();
        bit ok, fp_seen = 0, fp_checked = 0;
        int acc = 0, first_full = -1;
        logic full_after = 1'b0;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 8; i++) begin
            pcIn = 32'h200 + i * 4; addressIn = 32'h40 + i * 4; dataIn = $urandom;
            loadStore = 1'b1; alreadyFound = 1'b0; noIssue = 1'b0;
            if (queueFull && first_full < 0) first_full = i;
            if (!queueFull || doneValid) begin acc++; model(pcIn, addressIn, dataIn, 1'b1, 1'b0); end
            if (queueFull && doneValid && !fp_seen) fp_seen = 1;
            @(negedge clk);
            if (fp_seen && !fp_checked) begin full_after = queueFull; fp_checked = 1; end
        end
        noIssue = 1'b1;
        wait_drain(ok);
        total++; if (first_full != 6)    begin bad++; $display("FAIL fill_first_full got=%0d exp=6", first_full); end
        total++; if (acc != 7)           begin bad++; $display("FAIL fill_accepted got=%0d exp=7", acc); end
        total++; if (fp_seen != 1'b1)    begin bad++; $display("FAIL fill_full_pop_seen got=%b exp=1", fp_seen); end
        total++; if (full_after !== 1'b1) begin bad++; $display("FAIL fill_full_after_pop got=%b exp=1", full_after); end
        total++; if (!ok || obs_q.size() != exp_q.size())
            begin bad++; $display("FAIL fill_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].pc !== exp_q[i].pc || obs_q[i].data !== exp_q[i].data || obs_q[i].st !== exp_q[i].st)
                begin bad++; $display("FAIL fill_op%0d got pc=%h data=%h st=%b exp pc=%h data=%h st=%b", i,
                    obs_q[i].pc, obs_q[i].data, obs_q[i].st, exp_q[i].pc, exp_q[i].data, exp_q[i].st); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int c;
        logic [31:0] a = 32'h0BAD0000 | ($urandom & 32'hFFFF) | 32'h1;
        exp_q.delete(); obs_q.delete();
        offer(32'h300, 32'h20, a, 1'b1, 1'b0, c);
        offer(32'h304, 32'h20, 32'h0, 1'b0, 1'b0, c);
        wait_drain(ok);
        exp_q.delete(); obs_q.delete();
        // Store ~a bypassing the model: it is to be aborted by reset.
        pcIn = 32'h308; addressIn = 32'h20; dataIn = ~a; loadStore = 1'b1; alreadyFound = 1'b0; noIssue = 1'b0;
        @(negedge clk);
        noIssue = 1'b1;
        @(posedge clk); @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        total++; if (doneValid !== 1'b0)   begin bad++; $display("FAIL rmid_doneValid got=%b exp=0", doneValid); end
        total++; if (pcDone !== 32'h0)     begin bad++; $display("FAIL rmid_pcDone got=%h exp=0", pcDone); end
        total++; if (loadData !== 32'h0)   begin bad++; $display("FAIL rmid_loadData got=%h exp=0", loadData); end
        total++; if (doneIsStore !== 1'b0 || queueFull !== 1'b0)
            begin bad++; $display("FAIL rmid_flags got st=%b full=%b exp 0 0", doneIsStore, queueFull); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        offer(32'h30C, 32'h20, 32'h0, 1'b0, 1'b0, c);
        wait_drain(ok);
        total++; if (!ok || obs_q.size() != 1) begin bad++; $display("FAIL rmid_count got=%0d exp=1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            total++; if (obs_q[0].data !== a || obs_q[0].pc !== 32'h30C)
                begin bad++; $display("FAIL rmid_load got pc=%h data=%h exp pc=30c data=%h", obs_q[0].pc, obs_q[0].data, a); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int c;
        exp_q.delete(); obs_q.delete();
        for (int w = 0; w < 8; w++) offer(32'h400 + w * 4, w * 4, $urandom, 1'b1, 1'b0, c);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            else begin
                logic [31:0] addr = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
                offer(32'h1000 + i * 4, addr, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c);
            end
        end
        wait_drain(ok);
        total++; if (!ok || obs_q.size() != exp_q.size())
            begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].pc !== exp_q[i].pc || obs_q[i].data !== exp_q[i].data || obs_q[i].st !== exp_q[i].st)
                begin bad++; $display("FAIL b2b_op%0d got pc=%h data=%h st=%b exp pc=%h data=%h st=%b", i,
                    obs_q[i].pc, obs_q[i].data, obs_q[i].st, exp_q[i].pc, exp_q[i].data, exp_q[i].st); end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_forward();
        test_wrap();
        test_fill();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
